// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU request sequencer
//
// Purpose: opcode enum, request struct and result width used by alu_seq,
//          alu_seq_fifo and the ALU placed alongside them.
// Ports:   none (package).
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    alu_op_t    op;
  } alu_req_t;

  localparam int ALU_RES_W = 16;

endpackage

// File: rtl/alu_seq_fifo.sv
// rtl/alu_seq_fifo.sv - synchronous request FIFO for the ALU sequencer
//
// Purpose: DEPTH-entry FIFO of alu_req_t with occupancy count.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   push, push_data    write request (caller guarantees !full)
//   pop                remove head (caller guarantees !empty)
//   head               current head entry
//   full, empty        occupancy flags
//   level              number of stored entries
module alu_seq_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  alu_req_t                       push_data,
  input  logic                           pop,
  output alu_req_t                       head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  alu_req_t          r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign head  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted in r_level.
  always_ff @(posedge clk) begin
    if (rst_n && push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - request sequencer in front of a combinational ALU
//
// Purpose: buffers operand/opcode requests in a FIFO, drives the FIFO head
//          to an external ALU and registers its result behind a
//          valid/ready output stage.
// Option:  ALU_SEQ_STATS_EN adds the saturating op_count output.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready             request handshake
//   in_a, in_b, in_op             request operands and opcode
//   alu_a, alu_b, alu_op          FIFO head to the ALU (0,0,ADD when empty)
//   alu_result                    combinational ALU result
//   out_valid/out_ready           result handshake
//   out_result, out_op            registered result and its opcode
//   level                         FIFO occupancy (output register excluded)
//   op_count                      completed-result count (option only)
module alu_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_a,
  input  logic [7:0]                   in_b,
  input  alu_op_t                      in_op,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  output alu_op_t                      alu_op,
  input  logic [ALU_RES_W-1:0]         alu_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ALU_RES_W-1:0]         out_result,
  output alu_op_t                      out_op,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]                  op_count
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]             r_state;
  logic [ALU_RES_W-1:0]   r_out_result;
  alu_op_t                r_out_op;

  alu_req_t               w_req;
  alu_req_t               w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_load;
  logic                   w_out_valid;

  assign w_req       = '{a: in_a, b: in_b, op: in_op};
  assign w_out_valid = (r_state == ST_FULL);

  // Ready depends only on occupancy, so a full FIFO refuses even when it
  // is popping this cycle; this keeps in_ready off the out_ready path.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_load   = !w_empty && (!w_out_valid || out_ready);

  alu_seq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_req),
    .pop       (w_load),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (level)
  );

  // Stale FIFO storage must not reach the ALU when nothing is buffered.
  assign alu_a  = w_empty ? 8'd0    : w_head.a;
  assign alu_b  = w_empty ? 8'd0    : w_head.b;
  assign alu_op = w_empty ? ALU_ADD : w_head.op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_out_result <= '0;
      r_out_op     <= ALU_ADD;
    end else begin
      if (w_load) begin
        r_out_result <= alu_result;
        r_out_op     <= w_head.op;
      end
      case (r_state)
        ST_EMPTY: if (w_load) r_state <= ST_FULL;
        ST_FULL:  if (out_ready && !w_load) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid  = w_out_valid;
  assign out_result = r_out_result;
  assign out_op     = r_out_op;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_load && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
  import alu_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     in_a;
  logic [7:0]     in_b;
  alu_op_t        in_op;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  alu_op_t        alu_op;
  logic [15:0]    alu_result;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    out_result;
  alu_op_t        out_op;
  logic [2:0]     level;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]    op_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_seq #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .level      (level)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  // External combinational ALU.
  always_comb begin
    alu_result = 16'd0;
    case (alu_op)
      ALU_ADD: alu_result = {8'd0, alu_a} + {8'd0, alu_b};
      ALU_SUB: alu_result = {8'd0, alu_a} - {8'd0, alu_b};
      ALU_MUL: alu_result = {8'd0, alu_a} * {8'd0, alu_b};
      ALU_XOR: alu_result = {8'd0, alu_a ^ alu_b};
      default: alu_result = 16'd0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input alu_op_t op);
    in_valid = v;
    in_a = a;
    in_b = b;
    in_op = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 8'd0, ALU_ADD);
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_result !== 16'h0000) begin tests_failed++; $display("FAIL reset_out_result got %h want 0000", out_result); end
    tests_run++;
    if (out_op !== ALU_ADD) begin tests_failed++; $display("FAIL reset_out_op got %0d want 0", out_op); end
    tests_run++;
    if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", level); end
    tests_run++;
    if ({alu_a, alu_b, alu_op} !== 18'd0) begin
      tests_failed++; $display("FAIL reset_alu_drive got a=%h b=%h op=%0d want 0 0 0", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_add_latency();
    out_ready = 1'b1;
    drive(1'b1, 8'd200, 8'd100, ALU_ADD);
    step();
    drive(1'b0, 8'd0, 8'd0, ALU_ADD);
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd1 || alu_a !== 8'd200 || alu_b !== 8'd100) begin
      tests_failed++;
      $display("FAIL add_stage1 got out_valid=%b level=%0d alu_a=%0d alu_b=%0d want 0 1 200 100", out_valid, level, alu_a, alu_b);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_result !== 16'h012C || out_op !== ALU_ADD) begin
      tests_failed++;
      $display("FAIL add_result got valid=%b result=%h op=%0d want 1 012c 0", out_valid, out_result, out_op);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || out_result !== 16'h012C) begin
      tests_failed++;
      $display("FAIL add_drain got valid=%b result=%h want 0 012c", out_valid, out_result);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    alu_op_t     vo [3];
    logic [15:0] ve [3];
    va = '{8'd5, 8'd255, 8'hA5};
    vb = '{8'd10, 8'd255, 8'h0F};
    vo = '{ALU_SUB, ALU_MUL, ALU_XOR};
    ve = '{16'hFFFB, 16'hFE01, 16'h00AA};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, va[i], vb[i], vo[i]);
      else       drive(1'b0, 8'd0, 8'd0, ALU_ADD);
      step();
      if (i >= 1) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== ve[i-1] || out_op !== vo[i-1]) begin
          tests_failed++;
          $display("FAIL b2b_%0d got valid=%b result=%h op=%0d want 1 %h %0d", i-1, out_valid, out_result, out_op, ve[i-1], vo[i-1]);
        end
      end
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end got valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  va [5];
    logic [7:0]  vb [5];
    alu_op_t     vo [5];
    logic [15:0] ve [5];
    int          k;
    va = '{8'd1, 8'd10, 8'd3, 8'hF0, 8'd255};
    vb = '{8'd2, 8'd3, 8'd4, 8'h0F, 8'd255};
    vo = '{ALU_ADD, ALU_SUB, ALU_MUL, ALU_XOR, ALU_ADD};
    ve = '{16'h0003, 16'h0007, 16'h000C, 16'h00FF, 16'h01FE};
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (k < 5) drive(1'b1, va[k], vb[k], vo[k]);
      else       drive(1'b1, 8'd9, 8'd9, ALU_MUL);
      if (in_ready) k++;
      step();
      if (out_valid) begin
        tests_run++;
        if (out_result !== ve[0]) begin
          tests_failed++; $display("FAIL bp_stable_c%0d got %h want %h", c, out_result, ve[0]);
        end
      end
    end
    tests_run++;
    if (k !== 5) begin tests_failed++; $display("FAIL bp_accepted got %0d want 5", k); end
    tests_run++;
    if (in_ready !== 1'b0 || level !== 3'd4) begin
      tests_failed++; $display("FAIL bp_full got in_ready=%b level=%0d want 0 4", in_ready, level);
    end
    drive(1'b0, 8'd0, 8'd0, ALU_ADD);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== ve[i] || out_op !== vo[i]) begin
        tests_failed++;
        $display("FAIL bp_drain_%0d got valid=%b result=%h op=%0d want 1 %h %0d", i, out_valid, out_result, out_op, ve[i], vo[i]);
      end
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      tests_failed++; $display("FAIL bp_empty got valid=%b level=%0d want 0 0", out_valid, level);
    end
  endtask

  task automatic test_push_pop_wrap();
    // item i: ADD (i+1) + 16 = i + 17
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(i + 1), 8'd16, ALU_ADD);
      step();
    end
    tests_run++;
    if (level !== 3'd2 || out_valid !== 1'b1 || out_result !== 16'd17) begin
      tests_failed++;
      $display("FAIL pp_prefill got level=%0d valid=%b result=%h want 2 1 0011", level, out_valid, out_result);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 8'(j + 4), 8'd16, ALU_ADD);
      step();
      tests_run++;
      if (level !== 3'd2 || out_valid !== 1'b1 || out_result !== 16'(j + 18)) begin
        tests_failed++;
        $display("FAIL pp_cycle_%0d got level=%0d valid=%b result=%h want 2 1 %h", j, level, out_valid, out_result, 16'(j + 18));
      end
    end
    drive(1'b0, 8'd0, 8'd0, ALU_ADD);
    for (int j = 0; j < 2; j++) begin
      step();
      tests_run++;
      if (out_result !== 16'(j + 26)) begin
        tests_failed++; $display("FAIL pp_tail_%0d got %h want %h", j, out_result, 16'(j + 26));
      end
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      tests_failed++; $display("FAIL pp_empty got valid=%b level=%0d want 0 0", out_valid, level);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'd7, 8'd8, ALU_MUL);
      step();
    end
    tests_run++;
    if (level !== 3'd3 || out_valid !== 1'b1 || out_result !== 16'd56) begin
      tests_failed++;
      $display("FAIL rm_setup got level=%0d valid=%b result=%h want 3 1 0038", level, out_valid, out_result);
    end
    rst_n = 1'b0;
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1 || out_result !== 16'd0 || out_op !== ALU_ADD) begin
      tests_failed++;
      $display("FAIL rm_after got valid=%b level=%0d in_ready=%b result=%h op=%0d want 0 0 1 0000 0",
               out_valid, level, in_ready, out_result, out_op);
    end
    rst_n = 1'b1;
    drive(1'b0, 8'd0, 8'd0, ALU_ADD);
    step();
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      tests_failed++; $display("FAIL rm_idle got valid=%b level=%0d want 0 0", out_valid, level);
    end
  endtask

`ifdef ALU_SEQ_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'd1, 8'd1, ALU_ADD);
      step();
    end
    drive(1'b0, 8'd0, 8'd0, ALU_ADD);
    step();
    step();
    tests_run++;
    if (op_count !== 16'd3) begin tests_failed++; $display("FAIL stats_count got %0d want 3", op_count); end
    do_reset();
    tests_run++;
    if (op_count !== 16'd0) begin tests_failed++; $display("FAIL stats_reset got %0d want 0", op_count); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'd0, 8'd0, ALU_ADD);
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_backpressure();
    test_push_pop_wrap();
    test_reset_mid();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Request sequencer that sits directly upstream of the combinational ALU. It accepts operand/opcode requests over a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to the ALU and captures the 16-bit ALU result into a registered output stage with its own valid/ready handshake. This decouples producers from consumers and gives the ALU path a registered boundary.

## Interface
- DEPTH, 4, request FIFO entries; power of two, ≥2
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_a  in  8  operand A
- in_b  in  8  operand B
- in_op  in  alu_op_t (2)  opcode: ADD=0, SUB=1, MUL=2, XOR=3
- alu_a  out  8  operand A to ALU
- alu_b  out  8  operand B to ALU
- alu_op  out  alu_op_t  opcode to ALU
- alu_result  in  16  combinational result from ALU
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_result  out  16  registered result
- out_op  out  alu_op_t  opcode that produced out_result
- level  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register
- op_count  out  16  completed-result counter; present only with ALU_SEQ_STATS_EN

## Operation
- FIFO push: occurs when in_valid && in_ready.
- FIFO ready: in_ready = (level != DEPTH). No push-through when full, even if a pop occurs in the same cycle.
- ALU drive: alu_a, alu_b and alu_op = FIFO head fields when level > 0. When the FIFO is empty they are 0, 0, ADD.
- Load condition: load = (level > 0) && (!out_valid || out_ready).
- On load:
  - out_result <= alu_result, out_op <= head op, out_valid <= 1.
  - The head is popped in the same cycle.
- Output drain: out_valid && out_ready && !load -> out_valid <= 0. out_result and out_op keep their last value.
- Stall: while out_valid && !out_ready, out_result and out_op are held bit-stable and no pop occurs.
- Simultaneous push and pop: level is unchanged. Pointers advance modulo DEPTH and wrap with no bubble.
- Widths: the ALU defines the result. The block passes the 16-bit value through unmodified. No sign or overflow interpretation is applied: SUB wraps modulo 2^16 and MUL is the full 16-bit product.
- Output register state machine, two states:
  - EMPTY (out_valid=0) -> FULL on load.
  - FULL -> EMPTY on out_ready && !load.
  - FULL -> FULL on load, or on stall.

## Timing
- Reset values: in_ready=1, out_valid=0, out_result=0, out_op=ADD, level=0, alu_a=alu_b=0, alu_op=ADD, op_count=0.
- Reset mid-operation: all buffered and pending results are discarded. Handshake inputs in the reset cycle are ignored.
- Latency: a request accepted at edge t appears with out_valid=1 after edge t+1 (2 cycles), provided the output stage is free.
- Throughput: 1 result per cycle when out_ready is held high.
- Total buffering: DEPTH + 1 requests (FIFO plus output register) with out_ready held low.

## Configuration
- ALU_SEQ_STATS_EN defined:
  - op_count port exists.
  - It increments by 1 on every load and saturates at 16'hFFFF.
  - Reset clears it to 0.
- ALU_SEQ_STATS_EN undefined: the op_count port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package alu_pkg:
  - alu_op_t, the 2-bit enum ADD/SUB/MUL/XOR.
  - The request struct {a[8], b[8], op}.
  - The ALU result width constant (16).
- Sub-module alu_seq_fifo:
  - Synchronous FIFO parameterised on DEPTH.
  - Holds the request struct.
  - Provides push/pop/full/empty/level.
- The ALU is instantiated outside this block, alongside it, and is wired to alu_a, alu_b, alu_op and alu_result.

## Test plan
- ADD a=200, b=100 with out_ready=1 -> two cycles later out_valid=1, out_result=16'h012C, out_op=ADD.
- Back-to-back operations, one per cycle:
  - SUB 5-10 -> 16'hFFFB.
  - MUL 255*255 -> 16'hFE01.
  - XOR 8'hA5^8'h0F -> 16'h00AA.
  - Results arrive in order on consecutive cycles.
- Backpressure, DEPTH=4, out_ready=0, in_valid held:
  - Exactly 5 requests are accepted, then in_ready=0 and level=4.
  - out_result stays stable.
  - Releasing out_ready drains all 5 in order.
- Simultaneous push and pop at level=2 across 8 cycles -> level stays 2, pointers wrap, no lost or duplicated results.
- Assert rst_n=0 for one cycle with 3 requests buffered and out_valid=1 -> next cycle out_valid=0, level=0, in_ready=1, out_result=0.
- With ALU_SEQ_STATS_EN: complete 3 operations -> op_count=3. Reset -> op_count=0.
